// File: rtl/button_event_scheduler.sv
// Purpose : classify debounced button presses as short/long and serialise them onto one event port.
// Latency : btn_up at cycle t -> evt_valid at t+2 at the earliest; >=1 idle cycle between events.
// Backpres: offered event held stable until evt_ready; one pending slot per button, extra releases drop with overrun.
//
// Ports:
//   clk, rst              system clock (posedge) and asynchronous active-high reset
//   btn_down / btn_up     per-button 1-cycle press / release pulses from the debouncers
//   btn_state             per-button debounced level, 1 = pressed
//   evt_valid/evt_ready   event handshake; evt_id, evt_long valid while evt_valid
//   overrun               1-cycle pulse when a release is dropped because its button is already pending
module button_event_scheduler #(
    parameter int          N_BTN       = 4,
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int          CNT_W       = 26,
    parameter int          ID_W        = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_down,
    input  logic [N_BTN-1:0] btn_up,
    input  logic [N_BTN-1:0] btn_state,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_long,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LONG_THR  = CNT_W'(LONG_CYCLES);
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_BTN - 1);
    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_OFFER   = 1'b1;

    logic [CNT_W-1:0] cnt [N_BTN];
    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] long_q;
    logic [N_BTN-1:0] is_long;
    logic [N_BTN-1:0] accept_vec;
    logic [N_BTN-1:0] drop_vec;
    logic [0:0]       state;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  sel_id;
    logic             sel_found;
    logic             accept;
    int               rr_idx;

    // evt_valid is always high in OFFER, so the handshake reduces to state & ready.
    assign accept = (state == S_OFFER) && evt_ready;

    always_comb begin
        is_long    = '0;
        accept_vec = '0;
        for (int i = 0; i < N_BTN; i++) begin
            // Uses the count before this cycle's btn_down reload.
            is_long[i]    = (cnt[i] >= LONG_THR);
            accept_vec[i] = accept && (evt_id == ID_W'(i));
        end
    end

    // A release is only dropped if the slot stays occupied; an accept in the
    // same cycle frees the slot for the new event.
    assign drop_vec = btn_up & pend & ~accept_vec;

    // Hold counters: reload on press, count while held, saturate at threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (btn_down[i]) begin
                    cnt[i] <= '0;
                end else if (btn_state[i] && (cnt[i] < LONG_THR)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Pending slots. Set has priority over the accept clear of the same button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= '0;
            long_q  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= |drop_vec;
            for (int i = 0; i < N_BTN; i++) begin
                if (btn_up[i] && (!pend[i] || accept_vec[i])) begin
                    pend[i]   <= 1'b1;
                    long_q[i] <= is_long[i];
                end else if (accept_vec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pick: first pending button after last_grant, wrapping at N_BTN.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        rr_idx    = 0;
        for (int k = 1; k <= N_BTN; k++) begin
            rr_idx = int'(last_grant) + k;
            if (rr_idx >= N_BTN) begin
                rr_idx = rr_idx - N_BTN;
            end
            if (!sel_found && pend[ID_W'(rr_idx)]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(rr_idx);
            end
        end
    end

    // Offer FSM. Returning to IDLE after every accept guarantees the idle gap
    // and lets the accepted slot clear before the next arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            evt_long   <= 1'b0;
            last_grant <= LAST_INIT;
        end else if (state == S_IDLE) begin
            if (sel_found) begin
                evt_id    <= sel_id;
                evt_long  <= long_q[sel_id];
                evt_valid <= 1'b1;
                state     <= S_OFFER;
            end
        end else begin
            if (evt_ready) begin
                evt_valid  <= 1'b0;
                last_grant <= evt_id;
                state      <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Purpose : scoreboard bench for button_event_scheduler (N_BTN=4, LONG_CYCLES=8).
// Latency : inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpres: evt_ready driven by the stimulus to exercise hold/stability cases.
module tb_button_event_scheduler;

    typedef struct packed {
        logic [1:0] id;
        logic       lng;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] btn_down;
    logic [3:0] btn_up;
    logic [3:0] btn_state;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_long;
    logic       overrun;

    int   checks   = 0;
    int   failures = 0;
    int   rst_cnt  = 0;
    int   ovr_cnt  = 0;
    exp_t sbq[$];

    button_event_scheduler #(
        .N_BTN       (4),
        .LONG_CYCLES (8),
        .CNT_W       (4),
        .ID_W        (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_down  (btn_down),
        .btn_up    (btn_up),
        .btn_state (btn_state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_long  (evt_long),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge rst) rst_cnt++;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press_start(input logic [3:0] mask);
        btn_down  = btn_down | mask;
        btn_state = btn_state | mask;
        tick();
        btn_down  = btn_down & ~mask;
    endtask

    task automatic release_btn(input logic [3:0] mask);
        btn_up    = btn_up | mask;
        btn_state = btn_state & ~mask;
        tick();
        btn_up    = '0;
    endtask

    task automatic push(input logic [1:0] id, input logic lng);
        exp_t e;
        e.id  = id;
        e.lng = lng;
        sbq.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks offer
    // stability and the idle gap after each accept.
    initial begin
        logic pv, pa, pl;
        logic [1:0] pid;
        int seen_rst;
        exp_t e;
        pv = 1'b0; pa = 1'b0; pl = 1'b0; pid = '0; seen_rst = 0;
        forever begin
            @(negedge clk);
            if (rst || (seen_rst != rst_cnt)) begin
                seen_rst = rst_cnt;
                pv = 1'b0;
                pa = 1'b0;
            end else begin
                if (pa) begin
                    check(evt_valid == 1'b0, "idle_after_accept", 32'(evt_valid), 0);
                end else if (pv) begin
                    check(evt_valid && (evt_id == pid) && (evt_long == pl), "offer_stable",
                          32'({evt_valid, evt_id, evt_long}), 32'({1'b1, pid, pl}));
                end
                if (overrun) ovr_cnt++;
                if (evt_valid && evt_ready) begin
                    check(sbq.size() != 0, "unexpected_event", 32'({evt_id, evt_long}), 0);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check((evt_id == e.id) && (evt_long == e.lng), "event_id_long",
                              32'({evt_id, evt_long}), 32'({e.id, e.lng}));
                    end
                end
                pv  = evt_valid;
                pa  = evt_valid && evt_ready;
                pid = evt_id;
                pl  = evt_long;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        btn_down = '0; btn_up = '0; btn_state = '0; evt_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check(evt_valid == 1'b0, "rst_evt_valid", 32'(evt_valid), 0);
        check(evt_id == 2'd0,    "rst_evt_id",    32'(evt_id), 0);
        check(evt_long == 1'b0,  "rst_evt_long",  32'(evt_long), 0);
        check(overrun == 1'b0,   "rst_overrun",   32'(overrun), 0);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Short press on button 1: valid exactly at up+2 for one cycle.
        press_start(4'b0010);
        idle(3);
        push(2'd1, 1'b0);
        release_btn(4'b0010);
        @(negedge clk);
        check(evt_valid == 1'b0, "lat_t1", 32'(evt_valid), 0);
        @(negedge clk);
        check(evt_valid && (evt_id == 2'd1), "lat_t2", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd1}));
        @(negedge clk);
        check(evt_valid == 1'b0, "one_cycle_valid", 32'(evt_valid), 0);
        tick();
        idle(2);

        // Threshold boundary: hold 7 is short, hold 8 is long.
        press_start(4'b0001);
        idle(7);
        push(2'd0, 1'b0);
        release_btn(4'b0001);
        idle(4);
        press_start(4'b0001);
        idle(8);
        push(2'd0, 1'b1);
        release_btn(4'b0001);
        idle(4);

        // Reset mid-offer with buttons 0 and 2 pending (last_grant=0 -> 2 offered).
        evt_ready = 1'b0;
        press_start(4'b0101);
        idle(3);
        release_btn(4'b0101);
        idle(2);
        @(negedge clk);
        check(evt_valid && (evt_id == 2'd2), "pre_rst_offer", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd2}));
        #2 rst = 1'b1;
        #1;
        check(evt_valid == 1'b0, "async_rst_valid", 32'(evt_valid), 0);
        check(evt_id == 2'd0,    "async_rst_id",    32'(evt_id), 0);
        sbq.delete();
        tick();
        tick();
        rst = 1'b0;
        evt_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check(evt_valid == 1'b0, "post_rst_no_pending", 32'(evt_valid), 0);
        tick();

        // Buttons 0 and 3 together after reset: button 0 first.
        press_start(4'b1001);
        idle(2);
        push(2'd0, 1'b0);
        push(2'd3, 1'b0);
        release_btn(4'b1001);
        idle(6);

        // Again 0 and 3 (last_grant=3): 0 long, 3 short.
        press_start(4'b0001);
        idle(6);
        press_start(4'b1000);
        idle(3);
        push(2'd0, 1'b1);
        push(2'd3, 1'b0);
        release_btn(4'b1001);
        idle(6);

        // 1 and 3 with last_grant=3: 1 short first, then 3 long.
        press_start(4'b1000);
        idle(7);
        press_start(4'b0010);
        idle(3);
        push(2'd1, 1'b0);
        push(2'd3, 1'b1);
        release_btn(4'b1010);
        idle(6);

        // Long press on button 2 held off by ready=0 for 5 cycles.
        evt_ready = 1'b0;
        press_start(4'b0100);
        idle(20);
        push(2'd2, 1'b1);
        release_btn(4'b0100);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(evt_valid && (evt_id == 2'd2) && evt_long, "held_offer",
                  32'({evt_valid, evt_id, evt_long}), 32'({1'b1, 2'd2, 1'b1}));
        end
        tick();
        evt_ready = 1'b1;
        idle(4);

        // 1 and 3 with last_grant=2: 3 first, then 1.
        press_start(4'b1010);
        idle(2);
        push(2'd3, 1'b0);
        push(2'd1, 1'b0);
        release_btn(4'b1010);
        idle(6);

        // Second release of button 1 while pending: dropped, 1-cycle overrun.
        evt_ready = 1'b0;
        press_start(4'b0010);
        idle(10);
        push(2'd1, 1'b1);
        release_btn(4'b0010);
        idle(2);
        press_start(4'b0010);
        idle(1);
        release_btn(4'b0010);
        @(negedge clk);
        check(overrun == 1'b1, "overrun_pulse", 32'(overrun), 1);
        @(negedge clk);
        check(overrun == 1'b0, "overrun_width", 32'(overrun), 0);
        tick();
        evt_ready = 1'b1;
        idle(4);

        // Release of button 1 in the cycle its pending event is accepted.
        evt_ready = 1'b0;
        press_start(4'b0010);
        idle(2);
        push(2'd1, 1'b0);
        release_btn(4'b0010);
        idle(3);
        press_start(4'b0010);
        idle(9);
        evt_ready = 1'b1;
        push(2'd1, 1'b1);
        release_btn(4'b0010);
        @(negedge clk);
        check(evt_valid == 1'b0, "reaccept_idle", 32'(evt_valid), 0);
        @(negedge clk);
        check(evt_valid && (evt_id == 2'd1), "reaccept_offer", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd1}));
        tick();
        idle(3);

        for (int w = 0; (w < 50) && (sbq.size() != 0); w++) begin
            @(negedge clk);
        end
        check(sbq.size() == 0, "drain", 32'(sbq.size()), 0);
        check(ovr_cnt == 1, "overrun_total", 32'(ovr_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
